// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   fetch_state_e     : fetch FSM state encoding
//   DEFAULT_RESET_PC  : default PC after reset
//   DEFAULT_NOP_INSTR : default bubble instruction word
//   PC_INCR           : sequential PC step (one 32-bit word)
//   word_align()      : clears address bits [1:0]
package fetch_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_INCR           = 32'd4;
    localparam logic [31:0] PC_ALIGN_MASK     = 32'hFFFF_FFFC;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & PC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge bus.
//   imem_req   : fetch request valid (master -> slave)
//   imem_addr  : word-aligned fetch address (master -> slave)
//   imem_ack   : data for imem_addr returned this cycle (slave -> master)
//   imem_rdata : instruction word, valid with imem_ack (slave -> master)
interface fetch_stage_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: instruction word, next PC and valid flag.
//   clk, rst   : clock, synchronous active-high reset
//   flush      : insert a bubble (dr = NOP_INSTR, dr_valid = 0, npc kept)
//   load       : capture load_instr/load_npc as a valid instruction
//   (neither)  : hold current contents
//   dr, npc, dr_valid : register outputs
// flush wins over load.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        load,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_npc,
    output logic [31:0] dr,
    output logic [31:0] npc,
    output logic        dr_valid
);

    logic [31:0] dr_q, dr_d;
    logic [31:0] npc_q, npc_d;
    logic        dr_valid_q, dr_valid_d;

    always_comb begin
        dr_d       = dr_q;
        npc_d      = npc_q;
        dr_valid_d = dr_valid_q;
        if (flush) begin
            dr_d       = NOP_INSTR;
            dr_valid_d = 1'b0;
        end else if (load) begin
            dr_d       = load_instr;
            npc_d      = load_npc;
            dr_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dr_q       <= NOP_INSTR;
            npc_q      <= 32'h0000_0000;
            dr_valid_q <= 1'b0;
        end else begin
            dr_q       <= dr_d;
            npc_q      <= npc_d;
            dr_valid_q <= dr_valid_d;
        end
    end

    assign dr       = dr_q;
    assign npc      = npc_q;
    assign dr_valid = dr_valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues word fetches over imem and
// fills the IF/ID register for decode.
//   clk, rst    : clock, synchronous active-high reset
//   stall       : decode stall, freezes DR/npc/dr_valid
//   redirect    : branch/jump taken, flush and reload PC from redirect_pc
//   redirect_pc : redirect target (bits [1:0] ignored)
//   imem        : instruction-memory bus (master side)
//   DR, npc, dr_valid : IF/ID register outputs
//
// state | meaning
// ------+-------------------------------------------------------------
// FETCH | request outstanding at pc; IF/ID accepts new words
// HOLD  | word fetched while decode stalled sits in hold buffer; no req
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [31:0]          redirect_pc,
    fetch_stage_if.master        imem,
    output logic [31:0]          DR,
    output logic [31:0]          npc,
    output logic                 dr_valid
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  hold_instr_q, hold_instr_d;
    logic [31:0]  hold_npc_q, hold_npc_d;

    logic [31:0]  pc_inc;
    logic         ifid_flush;
    logic         ifid_load;
    logic [31:0]  ifid_instr;
    logic [31:0]  ifid_npc;

    assign pc_inc = pc_q + PC_INCR;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        hold_instr_d = hold_instr_q;
        hold_npc_d   = hold_npc_q;
        ifid_flush   = 1'b0;
        ifid_load    = 1'b0;
        ifid_instr   = imem.imem_rdata;
        ifid_npc     = pc_inc;

        if (redirect) begin
            // Any ack this cycle belongs to the wrong path and is dropped.
            pc_d         = word_align(redirect_pc);
            state_d      = FETCH;
            hold_instr_d = 32'h0000_0000;
            hold_npc_d   = 32'h0000_0000;
            ifid_flush   = 1'b1;
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (imem.imem_ack) begin
                        pc_d = pc_inc;
                        if (stall) begin
                            // Decode cannot take the word; park it and stop
                            // requesting until it drains.
                            hold_instr_d = imem.imem_rdata;
                            hold_npc_d   = pc_inc;
                            state_d      = HOLD;
                        end else begin
                            ifid_load = 1'b1;
                        end
                    end else if (!stall) begin
                        ifid_flush = 1'b1;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        ifid_load  = 1'b1;
                        ifid_instr = hold_instr_q;
                        ifid_npc   = hold_npc_q;
                        state_d    = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FETCH;
            pc_q         <= word_align(RESET_PC);
            hold_instr_q <= 32'h0000_0000;
            hold_npc_q   <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            hold_instr_q <= hold_instr_d;
            hold_npc_q   <= hold_npc_d;
        end
    end

    assign imem.imem_req  = (state_q == FETCH);
    assign imem.imem_addr = pc_q;

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk        (clk),
        .rst        (rst),
        .flush      (ifid_flush),
        .load       (ifid_load),
        .load_instr (ifid_instr),
        .load_npc   (ifid_npc),
        .dr         (DR),
        .npc        (npc),
        .dr_valid   (dr_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
    import fetch_pkg::*;

    localparam logic [31:0] RPC0  = 32'h0000_0000;
    localparam logic [31:0] RPC1  = 32'hFFFF_FFF8;
    localparam logic [31:0] MAGIC = 32'hA5A5_0000;
    localparam logic [31:0] NOP   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst, stall, redirect, ack;
    logic [31:0] redirect_pc;
    logic [31:0] dr0, npc0, dr1, npc1;
    logic        v0, v1;

    fetch_stage_if bus0 ();
    fetch_stage_if bus1 ();

    // Memory responder: word content is a fixed function of its address.
    assign bus0.imem_ack   = ack;
    assign bus0.imem_rdata = bus0.imem_addr ^ MAGIC;
    assign bus1.imem_ack   = ack;
    assign bus1.imem_rdata = bus1.imem_addr ^ MAGIC;

    always #5 clk = ~clk;

    fetch_stage dut0 (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem(bus0),
        .DR(dr0), .npc(npc0), .dr_valid(v0)
    );

    fetch_stage #(.RESET_PC(RPC1)) dut1 (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem(bus1),
        .DR(dr1), .npc(npc1), .dr_valid(v1)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Reference model: fetched-but-undelivered words wait in a queue; a new
    // fetch is requested only while nothing is waiting.
    logic [31:0] m_pc  [2];
    logic [31:0] m_dr  [2];
    logic [31:0] m_npc [2];
    logic        m_val [2];
    logic [63:0] pend  [2][$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_step(input int k, input logic [31:0] base);
        logic [63:0] e;
        if (rst) begin
            m_pc[k] = base; pend[k].delete();
            m_dr[k] = NOP; m_npc[k] = 32'h0; m_val[k] = 1'b0;
        end else if (redirect) begin
            m_pc[k] = {redirect_pc[31:2], 2'b00}; pend[k].delete();
            m_dr[k] = NOP; m_val[k] = 1'b0;
        end else begin
            if (pend[k].size() == 0 && ack) begin
                pend[k].push_back({m_pc[k] + 32'd4, m_pc[k] ^ MAGIC});
                m_pc[k] = m_pc[k] + 32'd4;
            end
            if (!stall) begin
                if (pend[k].size() > 0) begin
                    e = pend[k].pop_front();
                    m_dr[k] = e[31:0]; m_npc[k] = e[63:32]; m_val[k] = 1'b1;
                end else begin
                    m_dr[k] = NOP; m_val[k] = 1'b0;
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("dut0_req",   {31'h0, bus0.imem_req},  {31'h0, pend[0].size() == 0});
        chk("dut0_addr",  bus0.imem_addr,          m_pc[0]);
        chk("dut0_dr",    dr0,                     m_dr[0]);
        chk("dut0_npc",   npc0,                    m_npc[0]);
        chk("dut0_valid", {31'h0, v0},             {31'h0, m_val[0]});
        chk("dut1_req",   {31'h0, bus1.imem_req},  {31'h0, pend[1].size() == 0});
        chk("dut1_addr",  bus1.imem_addr,          m_pc[1]);
        chk("dut1_dr",    dr1,                     m_dr[1]);
        chk("dut1_npc",   npc1,                    m_npc[1]);
        chk("dut1_valid", {31'h0, v1},             {31'h0, m_val[1]});
    endtask

    task automatic cycle(input logic r, input logic st, input logic rd,
                         input logic [31:0] rpc, input logic ak);
        rst = r; stall = st; redirect = rd; redirect_pc = rpc; ack = ak;
        @(posedge clk);
        model_step(0, RPC0);
        model_step(1, RPC1);
        @(negedge clk);
        cyc++;
        compare_all();
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; ack = 1'b0;
        @(negedge clk);

        // Reset, then continuous acks (dut1 also wraps past 0xFFFF_FFFC).
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        chk("reset_addr0", bus0.imem_addr, RPC0);
        chk("reset_addr1", bus1.imem_addr, RPC1);
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 1);

        // Ack under stall, stall held, then drain.
        cycle(0, 1, 0, 0, 1);
        cycle(0, 1, 0, 0, 1);
        cycle(0, 1, 0, 0, 1);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);

        // Redirect coincident with ack: target alignment and discarded data.
        cycle(0, 0, 1, 32'h0000_0103, 1);
        chk("redir_addr", bus0.imem_addr, 32'h0000_0100);
        chk("redir_valid", {31'h0, v0}, 32'h0);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);

        // Redirect while holding a stalled word.
        cycle(0, 1, 0, 0, 1);
        cycle(0, 1, 1, 32'h0000_2001, 0);
        chk("hold_redir_req", {31'h0, bus0.imem_req}, 32'h1);
        chk("hold_redir_addr", bus0.imem_addr, 32'h0000_2000);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);

        // Ack every third cycle.
        for (int i = 0; i < 9; i++) cycle(0, 0, 0, 0, (i % 3) == 2);

        // Reset in the middle of HOLD.
        cycle(0, 1, 0, 0, 1);
        cycle(0, 1, 0, 0, 0);
        cycle(1, 1, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);

        // Randomized interleavings.
        for (int i = 0; i < 3000; i++) begin
            logic        r_rst, r_st, r_rd, r_ak;
            logic [31:0] r_pc;
            r_rst = ($urandom_range(63) == 0);
            r_rd  = ($urandom_range(15) == 0);
            r_st  = ($urandom_range(2) == 0);
            r_ak  = ($urandom_range(1) == 1);
            r_pc  = $urandom;
            if ($urandom_range(3) == 0) r_pc = 32'hFFFF_FFF0 | 32'($urandom_range(15));
            cycle(r_rst, r_st, r_rd, r_pc, r_ak);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
